// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// halt-drain length, counter width and pipeline-control vectors.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam int unsigned DRAIN_CYCLES  = 3;
  localparam logic [1:0]  DRAIN_LAST    = 2'(DRAIN_CYCLES - 1);
  localparam logic [4:0]  ECALL_ARG_REG = 5'd17;
  localparam int unsigned CNT_W         = 16;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_ADVANCE = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
  localparam ctrl_t CTRL_STALL   = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b1};
  localparam ctrl_t CTRL_REDIR   = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b1};
  localparam ctrl_t CTRL_HALTGO  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b0};

  // True when an ID source operand is actually read and names the EX destination.
  function automatic logic src_match(input logic use_src, input logic [4:0] rs, input logic [4:0] rd);
    return use_src && (rs == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_max_s;

  assign at_max_s = &count_q;

  // Next count: step by one unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && !at_max_s) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / ECALL-argument stalls, mispredict
// flushes, and an ECALL-triggered halt that drains EX/MEM/WB before freezing.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_is_ecall,
  input  logic        id_halt_req,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mispredict,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        is_halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  state_e     state_q;
  logic [1:0] drain_cnt_q;
  logic       is_halted_q;

  logic  load_use_s;
  logic  ecall_dep_s;
  logic  in_run_s;
  logic  stall_s;
  logic  flush_s;
  logic  halt_go_s;
  ctrl_t ctrl_s;

  // x0 is hardwired zero, so a load targeting it can never create a dependency.
  assign load_use_s  = ex_mem_read && (ex_rd != 5'd0) &&
                       (src_match(id_use_rs1, id_rs1, ex_rd) ||
                        src_match(id_use_rs2, id_rs2, ex_rd));
  assign ecall_dep_s = id_is_ecall && ex_reg_write && (ex_rd == ECALL_ARG_REG);

  assign in_run_s  = (state_q == ST_RUN);
  assign stall_s   = in_run_s && !ex_mispredict && (load_use_s || ecall_dep_s);
  assign flush_s   = in_run_s && ex_mispredict;
  assign halt_go_s = in_run_s && !ex_mispredict && !stall_s && id_halt_req;

  // Pipeline-register controls; a mispredict outranks stall and halt in RUN.
  always_comb begin
    ctrl_s = CTRL_STALL;
    case (state_q)
      ST_RUN: begin
        if (ex_mispredict) begin
          ctrl_s = CTRL_REDIR;
        end else if (stall_s) begin
          ctrl_s = CTRL_STALL;
        end else if (id_halt_req) begin
          ctrl_s = CTRL_HALTGO;
        end else begin
          ctrl_s = CTRL_ADVANCE;
        end
      end
      ST_DRAIN:  ctrl_s = CTRL_STALL;
      ST_HALTED: ctrl_s = CTRL_STALL;
      default:   ctrl_s = CTRL_STALL;
    endcase
  end

  assign pc_write     = ctrl_s.pc_write;
  assign if_id_write  = ctrl_s.if_id_write;
  assign if_id_flush  = ctrl_s.if_id_flush;
  assign id_ex_bubble = ctrl_s.id_ex_bubble;

  // Halt FSM with drain counter; an illegal encoding parks the core halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 2'd0;
      is_halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_go_s) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= 2'd0;
          end else begin
            state_q     <= ST_RUN;
          end
          is_halted_q <= 1'b0;
        end
        ST_DRAIN: begin
          drain_cnt_q <= drain_cnt_q + 2'd1;
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q     <= ST_HALTED;
            is_halted_q <= 1'b1;
          end else begin
            state_q     <= ST_DRAIN;
            is_halted_q <= 1'b0;
          end
        end
        ST_HALTED: begin
          state_q     <= ST_HALTED;
          is_halted_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_HALTED;
          drain_cnt_q <= 2'd0;
          is_halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign is_halted = is_halted_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_s),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_s),
    .count (flush_cnt)
  );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports id_rs1 and id_rs2, input, 5 each, source registers of the ID instruction.
REQ-005 The block SHALL have ports id_use_rs1 and id_use_rs2, input, 1 each; high when the ID instruction reads that source.
REQ-006 The block SHALL have port id_is_ecall, input, 1, ID instruction is ECALL.
REQ-007 The block SHALL have port id_halt_req, input, 1; ECALL in ID whose x17 value equals 10.
REQ-008 The block SHALL have ports ex_mem_read (1), ex_reg_write (1) and ex_rd (5), inputs, describing the EX-stage instruction.
REQ-009 The block SHALL have port ex_mispredict, input, 1, branch or jump resolved wrong in EX.
REQ-010 The block SHALL have ports pc_write, if_id_write, if_id_flush and id_ex_bubble, outputs, 1 each, pipeline-register controls.
REQ-011 The block SHALL have port is_halted, output, 1, sticky halt indication.
REQ-012 The block SHALL have ports stall_cnt and flush_cnt, outputs, 16 each, saturating statistics counters.

Function
REQ-013 The FSM SHALL have exactly three states: RUN, DRAIN and HALTED.
REQ-014 load_use SHALL be ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
REQ-015 ecall_dep SHALL be id_is_ecall && ex_reg_write && ex_rd==17.
REQ-016 stall SHALL be (load_use || ecall_dep) in RUN with ex_mispredict low.
REQ-017 In RUN with ex_mispredict=1, the block SHALL drive pc_write=1, if_id_flush=1, id_ex_bubble=1 and if_id_write=1, and SHALL ignore stall and id_halt_req.
REQ-018 In RUN with stall=1, the block SHALL drive pc_write=0, if_id_write=0, id_ex_bubble=1 and if_id_flush=0.
REQ-019 In RUN otherwise, the block SHALL drive pc_write=1, if_id_write=1 and id_ex_bubble=0 (with if_id_flush=0), all combinationally in the same cycle.
REQ-020 RUN SHALL transition to DRAIN when id_halt_req=1, ex_mispredict=0 and stall=0; in that cycle the block SHALL drive pc_write=0 and if_id_write=0.
REQ-021 In DRAIN and HALTED, the block SHALL drive pc_write=0, if_id_write=0, id_ex_bubble=1 and if_id_flush=0, and SHALL ignore ex_mispredict.
REQ-022 A 2-bit drain counter SHALL load 0 on entry to DRAIN, increment each DRAIN cycle, and move the FSM to HALTED on the cycle the counter equals 2 (3 DRAIN cycles covering EX, MEM and WB).
REQ-023 HALTED SHALL be absorbing until reset, and is_halted SHALL be registered, high exactly when the state is HALTED.
REQ-024 stall_cnt SHALL increment on each RUN cycle with stall=1, and flush_cnt SHALL increment on each RUN cycle with ex_mispredict=1.
REQ-025 stall_cnt and flush_cnt SHALL saturate at 0xFFFF without wrapping.
REQ-026 When ex_rd=0, the block SHALL never produce load_use.

Reset
REQ-027 When reset=1 at a clock edge, the block SHALL set state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0 and is_halted=0, overriding any transition that cycle, including mid-DRAIN or in HALTED.
REQ-028 In the cycle following reset, outputs SHALL follow the RUN rules.

Structure
REQ-029 A shared package SHALL hold the state encoding (RUN=0, DRAIN=1, HALTED=2), DRAIN_CYCLES=3, ECALL_ARG_REG=17 and CNT_W=16.
REQ-030 One sub-module, sat_counter (parameter width, ports clk, reset, inc, count), SHALL be instantiated twice for stall_cnt and flush_cnt.

Verification
REQ-031 The bench SHALL cover ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> pc_write=0, if_id_write=0, id_ex_bubble=1, stall_cnt 0->1.
REQ-032 The bench SHALL cover the REQ-031 load-use stimulus with ex_mispredict=1 in the same cycle -> if_id_flush=1, pc_write=1, stall_cnt unchanged, flush_cnt +1.
REQ-033 The bench SHALL cover ex_mem_read=1, ex_rd=0, id_rs1=0, id_use_rs1=1 -> no stall, pc_write=1.
REQ-034 The bench SHALL cover id_halt_req=1 for one cycle in RUN -> DRAIN for 3 cycles, then is_halted=1 on the 4th edge and stays 1 for 10 further cycles.
REQ-035 The bench SHALL cover reset=1 asserted during the 2nd DRAIN cycle -> next cycle state=RUN, is_halted=0, pc_write=1, counters 0.
REQ-036 The bench SHALL cover 70000 consecutive stall cycles -> stall_cnt=0xFFFF, no wrap.
